// File: rtl/joy_db15_tx.sv
`default_nettype none
// ============================================================================
//  Module      : joy_db15_tx
//  Description : Device-side responder for the DB15 serial joystick link.
//                Emulates a 74HC165-style parallel-in/serial-out adapter that
//                the DB15 receiver polls over JOY_LOAD / JOY_CLK / JOY_DATA.
//                Two 16-bit joystick words are captured while load is low and
//                shifted out LSB first (player 1 bit 0 first) on each rising
//                edge of the receiver's shift clock.
//  Ports       : clk          - system clock (CLK_JOY, 40-50 MHz)
//                reset        - synchronous, active-high
//                joystick1/2  - button words, active-high pressed
//                joy_clk_in   - receiver shift clock (asynchronous)
//                joy_load_in  - receiver load strobe, active-low (asynchronous)
//                joy_data_out - serial data, active-low on wire, idles 1
//                frame_done   - one-cycle pulse when the last bit is shifted past
//                bit_count    - bits shifted since last load, saturates
//  Revision    : 1.0 - initial release
// ============================================================================
module joy_db15_tx #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] joystick1,
  input  logic [15:0] joystick2,
  input  logic        joy_clk_in,
  input  logic        joy_load_in,
  output logic        joy_data_out,
  output logic        frame_done,
  output logic [5:0]  bit_count
);

  localparam logic [5:0] C_FRAME_CNT = 6'(FRAME_BITS);

  // Synchronizer chains, reset to 1 so a low line at reset release is seen
  // as a fall (never a spurious rise).
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] load_sync_q, load_sync_d;
  logic                   clk_prev_q, clk_prev_d;

  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [5:0]             count_q, count_d;
  logic                   done_q, done_d;
  logic                   data_q, data_d;

  logic [31:0]            wire_word;
  logic                   clk_rise;
  logic                   load_low;

  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], joy_clk_in};
    load_sync_d = {load_sync_q[SYNC_STAGES-2:0], joy_load_in};
    clk_prev_d  = clk_sync_q[SYNC_STAGES-1];

    clk_rise  = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
    load_low  = ~load_sync_q[SYNC_STAGES-1];

    // Wire is active-low: a pressed button (1) is driven as 0.
    wire_word = ~{joystick2, joystick1};

    shift_d = shift_q;
    count_d = count_q;
    done_d  = 1'b0;

    if (load_low) begin
      // Transparent parallel load; any shift edge in this cycle is dropped.
      shift_d = wire_word[FRAME_BITS-1:0];
      count_d = 6'd0;
    end else if (clk_rise) begin
      // Ones fill from the top so an over-clocked frame reads as released.
      shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
      if (count_q != C_FRAME_CNT) begin
        count_d = count_q + 6'd1;
        if (count_q == C_FRAME_CNT - 6'd1) begin
          done_d = 1'b1;
        end
      end
    end

    // Output stage adds the final register of the SYNC_STAGES+2 latency.
    data_d = shift_q[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= '1;
      load_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      shift_q     <= '1;
      count_q     <= 6'd0;
      done_q      <= 1'b0;
      data_q      <= 1'b1;
    end else begin
      clk_sync_q  <= clk_sync_d;
      load_sync_q <= load_sync_d;
      clk_prev_q  <= clk_prev_d;
      shift_q     <= shift_d;
      count_q     <= count_d;
      done_q      <= done_d;
      data_q      <= data_d;
    end
  end

  assign joy_data_out = data_q;
  assign frame_done   = done_q;
  assign bit_count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_joy_db15_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_joy_db15_tx
//  Description : Directed self-checking bench for joy_db15_tx.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_joy_db15_tx;

  logic        clk;
  logic        reset;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic        joy_clk_in;
  logic        joy_load_in;
  logic        joy_data_out;
  logic        frame_done;
  logic [5:0]  bit_count;

  int n_cmp;
  int n_err;
  int fd_pulses;
  int fd_at;
  int cur_rise;

  joy_db15_tx #(
    .SYNC_STAGES (2),
    .FRAME_BITS  (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .joystick1    (joystick1),
    .joystick2    (joystick2),
    .joy_clk_in   (joy_clk_in),
    .joy_load_in  (joy_load_in),
    .joy_data_out (joy_data_out),
    .frame_done   (frame_done),
    .bit_count    (bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // frame_done monitor: every high cycle is counted, so one 1-cycle pulse
  // per frame shows up as an increment of exactly 1.
  initial begin
    fd_pulses = 0;
    fd_at     = -1;
  end
  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      fd_pulses = fd_pulses + 1;
      fd_at     = cur_rise;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_load();
    joy_load_in = 1'b0;
    ticks(6);
    joy_load_in = 1'b1;
    ticks(6);
  endtask

  task automatic rise_pulse(input int k);
    cur_rise   = k;
    joy_clk_in = 1'b1;
    ticks(4);
    joy_clk_in = 1'b0;
    ticks(4);
  endtask

  // Samples the line just before each rise, as the receiver does.
  task automatic shift_capture(input int n, output logic [63:0] cap);
    cap = '0;
    for (int i = 0; i < n; i++) begin
      cap[i] = joy_data_out;
      rise_pulse(i + 1);
    end
  endtask

  logic [63:0] cap;
  int          base;
  int          lat;

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    cur_rise    = 0;
    reset       = 1'b1;
    joystick1   = 16'h0000;
    joystick2   = 16'h0000;
    joy_clk_in  = 1'b0;
    joy_load_in = 1'b1;

    // Reset state
    ticks(3);
    chk("rst_data", 64'(joy_data_out), 64'h1);
    chk("rst_count", 64'(bit_count), 64'h0);
    chk("rst_done", 64'(frame_done), 64'h0);

    // Idle after reset with clk low: no spurious edge, nothing moves
    reset = 1'b0;
    ticks(12);
    chk("idle_data", 64'(joy_data_out), 64'h1);
    chk("idle_count", 64'(bit_count), 64'h0);
    chk("idle_no_done", 64'(fd_pulses), 64'h0);

    // Frame: j1=0001 j2=8000 -> wire word 7FFF_FFFE
    joystick1 = 16'h0001;
    joystick2 = 16'h8000;
    do_load();
    base = fd_pulses;
    shift_capture(32, cap);
    ticks(2);
    chk("f1_stream", cap[31:0], 64'h7FFF_FFFE);
    chk("f1_count", 64'(bit_count), 64'd32);
    chk("f1_done_cnt", 64'(fd_pulses - base), 64'd1);
    chk("f1_done_at", 64'(fd_at), 64'd32);
    chk("f1_data_after", 64'(joy_data_out), 64'h1);

    // Latency from a clk rise to the data line changing (bit0=0 -> bit1=1)
    do_load();
    chk("lat_bit0", 64'(joy_data_out), 64'h0);
    cur_rise   = 1;
    joy_clk_in = 1'b1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      if (joy_data_out !== 1'b0) break;
    end
    chk("lat_cycles", 64'(lat), 64'd4);
    ticks(4);
    joy_clk_in = 1'b0;
    ticks(4);

    // Load held low: clk edges ignored, latest joystick value captured
    joystick1   = 16'h0000;
    joystick2   = 16'h0000;
    joy_load_in = 1'b0;
    ticks(6);
    cur_rise   = 0;
    joy_clk_in = 1'b1;
    ticks(4);
    joy_clk_in = 1'b0;
    ticks(4);
    joy_clk_in = 1'b1;
    ticks(4);
    chk("hold_count", 64'(bit_count), 64'h0);
    joystick1 = 16'hFFFF;
    ticks(4);
    joy_clk_in = 1'b0;
    ticks(4);
    joy_load_in = 1'b1;
    ticks(6);
    chk("hold_count_rel", 64'(bit_count), 64'h0);
    shift_capture(16, cap);
    chk("hold_stream", cap[15:0], 64'h0);

    // Over-clocked frame, nothing pressed: all ones, saturating count
    joystick1 = 16'h0000;
    joystick2 = 16'h0000;
    do_load();
    base = fd_pulses;
    shift_capture(40, cap);
    ticks(2);
    chk("sat_stream", cap[39:0], 64'hFF_FFFF_FFFF);
    chk("sat_count", 64'(bit_count), 64'd32);
    chk("sat_done_cnt", 64'(fd_pulses - base), 64'd1);

    // Reset mid-frame: pattern word C3A5_5A3C, bit 10 is 0
    joystick1 = 16'hA5C3;
    joystick2 = 16'h3C5A;
    do_load();
    shift_capture(10, cap);
    chk("mid_data_pre", 64'(joy_data_out), 64'h0);
    chk("mid_count_pre", 64'(bit_count), 64'd10);
    reset = 1'b1;
    tick();
    chk("mid_rst_data", 64'(joy_data_out), 64'h1);
    chk("mid_rst_count", 64'(bit_count), 64'h0);
    reset = 1'b0;
    ticks(4);
    do_load();
    base = fd_pulses;
    shift_capture(32, cap);
    ticks(2);
    chk("f2_stream", cap[31:0], 64'hC3A5_5A3C);
    chk("f2_count", 64'(bit_count), 64'd32);
    chk("f2_done_cnt", 64'(fd_pulses - base), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/joy_db15_tx.md
Name: joy_db15_tx

Overview:
- Device-side responder for the DB15 serial joystick interface: emulates the parallel-in/serial-out shift-register adapter that the DB15 receiver polls over JOY_LOAD/JOY_CLK/JOY_DATA.
- Captures two 16-bit joystick words and serializes them onto the data line as the receiver clocks it.
- Used as the loopback/bench partner for the receiver and as a USER-port adapter emulator on a second board.
- Lives in the CLK_JOY domain (40-50 MHz); the receiver's strobes are treated as asynchronous.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on joy_clk_in/joy_load_in (min 2).
- FRAME_BITS, 32, bits per frame (player 1 then player 2, 16 each); legal values 16..32.

Ports:
- clk  in  1  system clock, 40-50 MHz.
- reset  in  1  synchronous, active-high.
- joystick1  in  16  player-1 buttons, active-high pressed.
- joystick2  in  16  player-2 buttons, active-high pressed.
- joy_clk_in  in  1  receiver shift clock, async.
- joy_load_in  in  1  receiver parallel-load strobe, active-low, async.
- joy_data_out  out  1  serial data, active-low on wire (0 = pressed), idles 1.
- frame_done  out  1  one-cycle pulse when the last frame bit has been shifted past.
- bit_count  out  6  bits shifted since the last load; saturates at FRAME_BITS.

Behaviour:
- Reset values: joy_data_out=1, frame_done=0, bit_count=0, shift register all ones, both synchronizer chains all ones.
- Synchronizers:
  - Each async input passes through SYNC_STAGES flops, then one edge-detect flop.
  - load_low = synced load == 0.
  - clk_rise = synced clk 0->1.
- Wire word: W = ~{joystick2, joystick1}, truncated to FRAME_BITS LSBs. Bit 0 of joystick1 is transmitted first.
- LOAD state, entered while load_low (74HC165 semantics):
  - shift register reloads from W every cycle, so it stays transparent while load is held.
  - bit_count=0.
  - joy_data_out = W[0] of the current cycle, registered, so visible 1 cycle later.
  - clk_rise is ignored while load_low.
- SHIFT state, entered on the cycle load_low deasserts. On each clk_rise:
  - register shifts right; a 1 enters at the MSB.
  - joy_data_out takes the new bit 0.
  - bit_count increments.
- Frame end:
  - When bit_count goes FRAME_BITS-1 -> FRAME_BITS, pulse frame_done for exactly 1 cycle.
  - Further clk_rise edges: bit_count stays at FRAME_BITS, joy_data_out stays 1, no further frame_done.
- Latency: joy_data_out updates SYNC_STAGES+2 clk cycles after a joy_clk_in rise or a joy_load_in fall. The receiver must hold each JOY_CLK phase at least SYNC_STAGES+3 cycles.
- Simultaneous load_low and clk_rise in the same cycle: load wins, no shift, bit_count=0.
- Glitches: a clk pulse shorter than one clk period may be missed and is not required to be counted. Only synchronized levels matter.
- Reset mid-frame: all state returns to reset values. joy_data_out=1 until the next load. clk_rise edges before the first load shift ones and count normally (no frame_done until FRAME_BITS is reached).
- No spurious edge out of reset: synchronizers reset to 1, so a line that is low at reset release registers as a fall, never a rise.
- Joystick inputs are not synchronized separately. They are sampled only during LOAD; changes during SHIFT do not affect the frame in flight.

Test Plan:
- Reset, then hold joy_load_in=1 and joy_clk_in=0 -> joy_data_out=1, bit_count=0, frame_done never asserts.
- joystick1=16'h0001, joystick2=16'h8000, one load pulse, then 32 joy_clk_in rises of 8 cycles each:
  - sampled stream is 0 followed by thirty 1s, ending in 0 (bit 31 = ~joystick2[15]).
  - frame_done pulses once, 1 cycle, at the 32nd rise.
  - bit_count reaches 32.
- Timing check: measure clk cycles from joy_clk_in rise to joy_data_out change -> exactly SYNC_STAGES+2 = 4 with defaults.
- Hold load low while changing joystick1 from 16'h0000 to 16'hFFFF, then release and shift -> first 16 bits are all 0 (latest value transmitted); load-low clk edges do not advance bit_count.
- 40 rises after one load with all buttons released -> all 40 bits are 1, bit_count saturates at 32, a single frame_done pulse.
- Assert reset after 10 shifts of a pattern frame -> joy_data_out=1 and bit_count=0 the next cycle; a following load and 32 shifts reproduce the full pattern correctly.
